// File: rtl/val_arb_pkg.sv
// Shared types and constants for the round-robin value arbiter.
// Burst mode is selected at build time with VAL_ARB_BURST_EN.
package val_arb_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam int VAL_W = 4;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/val_rr_arbiter_if.sv
// Requester and downstream handshake bundle of the value arbiter.
// The master side is the arbiter; the slave side is its environment.
interface val_rr_arbiter_if
  import val_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = VAL_W
);

  localparam int GW = grant_w(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready;
  logic [GW-1:0]     out_grant;
  logic              busy;

  modport master (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_grant,
    output busy
  );

  modport slave (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_grant,
    input  busy
  );

endinterface

// File: rtl/val_rr_pick.sv
// Combinational rotate-priority picker: first set request
// after 'last', wrapping modulo NREQ.
module val_rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [GW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = GW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/val_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output stage.
// Define VAL_ARB_BURST_EN to let a requester keep up to BURST_LEN beats.
module val_rr_arbiter
  import val_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int W         = VAL_W,
  parameter int BURST_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  val_rr_arbiter_if.master  bus
);

  localparam int GW = grant_w(NREQ);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  state_e            state;
  state_e            state_nx;
  logic              can_load;
  logic              accept;
  logic [NREQ-1:0]   pick_oh;
  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic [NREQ-1:0]   win_oh;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     last_grant;
  logic [W-1:0]      data_q;
  logic [GW-1:0]     grant_q;

  val_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req    (bus.req_valid),
    .last   (last_grant),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef VAL_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [CW-1:0] beat_cnt;
  logic          hold;

  // Owner keeps the stage while its burst is live and it still asks.
  assign hold = (beat_cnt != '0)
             && (beat_cnt < CW'(BURST_LEN))
             && bus.req_valid[last_grant];

  always_comb begin
    win_oh  = pick_oh;
    win_idx = pick_idx;
    if (hold) begin
      win_oh  = NREQ'(1) << last_grant;
      win_idx = last_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (can_load) begin
      if (accept)
        beat_cnt <= hold ? beat_cnt + CW'(1) : CW'(1);
      else
        beat_cnt <= '0;
    end
  end
`else
  assign win_oh  = pick_oh;
  assign win_idx = pick_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    can_load      = (state == IDLE) || bus.out_ready;
    accept        = can_load && pick_any && !rst;
    bus.req_ready = accept ? win_oh : '0;
    unique case (state)
      IDLE: if (accept) state_nx = SEND;
      SEND: begin
        if (accept)             state_nx = SEND;
        else if (bus.out_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      grant_q    <= '0;
      last_grant <= LAST_RST;
    end else if (accept) begin
      data_q     <= bus.req_data[win_idx*W +: W];
      grant_q    <= win_idx;
      last_grant <= win_idx;
    end
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_grant = grant_q;
  assign bus.busy      = !rst && ((state == SEND) || (|bus.req_valid));

endmodule

// File: tb/tb_val_rr_arbiter.sv
// Directed bench for val_rr_arbiter with NREQ=4, W=4.
// Burst expectations switch with VAL_ARB_BURST_EN.
module tb_val_rr_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   bexp [9];

  val_rr_arbiter_if #(.NREQ(4), .W(4)) bus ();

  val_rr_arbiter #(
    .NREQ      (4),
    .W         (4),
    .BURST_LEN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
`ifdef VAL_ARB_BURST_EN
    bexp = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
    bexp = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = 16'h4321;
    bus.out_ready = 1'b1;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_data",  32'(bus.out_data),  0);
      check("rst_grant", 32'(bus.out_grant), 0);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_busy",  32'(bus.busy),      0);
    end

    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rot_ready", 32'(bus.req_ready), 1 << (k % 4));
      @(posedge clk); #1;
      check("rot_valid", 32'(bus.out_valid), 1);
      check("rot_data",  32'(bus.out_data),  (k % 4) + 1);
      check("rot_grant", 32'(bus.out_grant), k % 4);
    end

    bus.out_ready = 1'b0;
    #1;
    repeat (5) begin
      check("bp_ready", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_data",  32'(bus.out_data),  4);
      check("bp_grant", 32'(bus.out_grant), 3);
    end

    bus.req_valid = 4'b0100;
    bus.req_data  = 16'h4A21;
    bus.out_ready = 1'b1;
    #1;
    check("sp_ready", 32'(bus.req_ready), 4);
    check("sp_busy",  32'(bus.busy),      1);
    @(posedge clk); #1;
    check("sp_data",  32'(bus.out_data),  32'hA);
    check("sp_grant", 32'(bus.out_grant), 2);

    bus.req_valid = 4'b0000;
    #1;
    check("dr_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    check("dr_valid", 32'(bus.out_valid), 0);
    check("dr_busy",  32'(bus.busy),      0);

    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    check("ar_pre", 32'(bus.out_valid), 1);
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.out_valid), 0);
    check("ar_data",  32'(bus.out_data),  0);
    bus.req_valid = 4'hF;
    #1;
    check("ar_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    check("ar_hold", 32'(bus.out_valid), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("ar_first", 32'(bus.req_ready), 1);

    bus.req_valid = 4'b0011;
    #1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check("bu_grant", 32'(bus.out_grant), bexp[k]);
      check("bu_data",  32'(bus.out_data),  bexp[k] + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/val_rr_arbiter.md
# val_rr_arbiter

Round-robin arbiter that shares the 4-bit value path between several requesters. Each requester offers a value with a valid/ready handshake. The arbiter picks one winner per beat, registers its value into a single output stage, and presents that stage to the downstream consumer through its own valid/ready handshake. It is the front-end sequencer for the value datapath whenever more than one source must drive it.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, value width in bits
- BURST_LEN, 4, maximum consecutive beats granted to one requester (used only when burst mode is compiled in)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester value valid
- req_data  in  NREQ*W  packed values; requester i occupies bits [i*W +: W]
- req_ready  out  NREQ  one-hot accept; a beat transfers when req_valid[i] and req_ready[i] are both high
- out_valid  out  1  output stage holds a value
- out_data  out  W  registered value
- out_ready  in  1  downstream accepts out_data
- out_grant  out  clog2(NREQ)  index of the requester whose value is in out_data
- busy  out  1  high when out_valid is high or any req_valid is high

## Operation
- Two states: IDLE (stage empty) and SEND (stage full).
- The stage can load in a cycle when:
  - state is IDLE, or
  - state is SEND and out_ready is high.
- Winner selection:
  - The winner is the first i with req_valid[i] set, searching from last_grant+1 upward with wrap-around modulo NREQ.
  - req_ready is combinational: it is the one-hot of the winner, gated by the can-load condition above.
  - req_ready is never high for a requester whose req_valid is low.
- On an accept:
  - out_data is loaded with the winner's value.
  - out_grant is loaded with the winner's index.
  - last_grant is updated to the winner's index.
  - Next state is SEND.
- In SEND, if out_ready is high and no req_valid is set, out_valid clears and the state returns to IDLE.
- In SEND with out_ready low, out_data and out_grant hold and every req_ready bit is 0. Requesters must hold req_valid and req_data until accepted.
- Reset values:
  - out_valid = 0, out_data = 0, out_grant = 0, busy = 0, state IDLE.
  - last_grant = NREQ-1, so requester 0 wins first after reset.
- Reset asserted mid-transfer clears the stage immediately (asynchronously) and discards its value. No req_ready is asserted while rst is high.
- All index arithmetic is modulo NREQ on clog2(NREQ) bits, with explicit wrap when NREQ is not a power of two.

## Timing
- Latency: a value accepted at edge N is visible on out_data with out_valid high after edge N.
- Throughput: one beat per cycle when out_ready is held high and requests are pending. There are no bubbles between back-to-back beats.
- A requester asserting req_valid while the stage is full waits at least until the cycle in which out_ready is high.
- Fairness: with all NREQ requesters continuously valid and burst mode compiled out, each is granted exactly once in every NREQ consecutive beats.

## Configuration
- Macro: VAL_ARB_BURST_EN.
- Defined (burst mode):
  - A beat counter tracks consecutive grants to the current requester.
  - If the current requester is still valid at the next load opportunity and fewer than BURST_LEN beats have been granted, it wins again regardless of rotation.
  - last_grant advances only when the burst ends: either after BURST_LEN beats, or on the first load opportunity at which the owner's req_valid is low.
- Undefined: strict rotation on every beat. The beat counter logic is absent and BURST_LEN is ignored.

## Structure
- Shared package val_arb_pkg holds:
  - the state enum (IDLE, SEND)
  - the default width constant VAL_W = 4
  - the function that computes the grant index width
- Sub-module val_rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot winner, winner index, any-request flag.
- The top level holds the state register, the output stage and the burst counter.

## Test plan
- Reset: assert rst with all req_valid high. Expect out_valid=0, out_data=0 and req_ready=0 throughout reset. After release, requester 0 is accepted first.
- Rotation: NREQ=4, requesters carry values 0x1/0x2/0x3/0x4, all valid, out_ready=1. Expect out_data 1,2,3,4,1,… on consecutive cycles, out_grant 0,1,2,3,0, and no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid high. Expect out_data and out_grant stable and req_ready=0 for all 5 cycles.
- Sparse request: only requester 2 valid with 0xA after last_grant=3. Expect req_ready=4'b0100, then out_data=0xA and out_grant=2 one cycle later.
- Async reset mid-stream: pulse rst between clock edges while out_valid=1. Expect out_valid to fall immediately, before the next edge.
- VAL_ARB_BURST_EN with BURST_LEN=4: requesters 0 and 1 both continuously valid. Expect grants 0,0,0,0,1,1,1,1,0.
